inst_loop_ctrl: RTL and testbench

- Instruction sequencer directly downstream of the CSR block.
- Consumes the loop-mode, jump, end and count fields, plus the start/clear pulses the CSR block generates.
- Produces the instruction-memory PC stream for the core decoder, handling up to three nested hardware loops.
- Returns busy/done status; busy feeds the CSR core-settings busy bit.

---
 rtl/inst_loop_ctrl.sv | 153 +++++++++++++++
 tb/tb_inst_loop_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_loop_ctrl.sv
// Loop-aware instruction sequencer: PC stream with up to three nested loops.
// Optional run-cycle counter enabled by INST_LOOP_CTRL_PERF_CNT_EN.
module inst_loop_ctrl #(
    parameter int unsigned InstMemDepth     = 32,
    parameter int unsigned InstMemAddrWidth = $clog2(InstMemDepth),
    parameter int unsigned PerfCntWidth     = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        clr_i,
    input  logic                        stall_i,
    input  logic [1:0]                  loop_mode_i,
    input  logic [InstMemAddrWidth-1:0] jump_addr1_i,
    input  logic [InstMemAddrWidth-1:0] jump_addr2_i,
    input  logic [InstMemAddrWidth-1:0] jump_addr3_i,
    input  logic [InstMemAddrWidth-1:0] end_addr1_i,
    input  logic [InstMemAddrWidth-1:0] end_addr2_i,
    input  logic [InstMemAddrWidth-1:0] end_addr3_i,
    input  logic [InstMemAddrWidth-1:0] count1_i,
    input  logic [InstMemAddrWidth-1:0] count2_i,
    input  logic [InstMemAddrWidth-1:0] count3_i,
    output logic [InstMemAddrWidth-1:0] pc_o,
    output logic                        inst_valid_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [PerfCntWidth-1:0]     perf_cycles_o
);

    localparam int unsigned AW = InstMemAddrWidth;
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;
    localparam logic [AW-1:0] LastAddr = AW'(InstMemDepth - 1);

    typedef logic [2:0][AW-1:0] triple_t;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [1:0]    mode_q, mode_d;
    triple_t       iter_q, iter_d;
    triple_t       jump_q, jump_d;
    triple_t       end_q, end_d;
    triple_t       cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          jumped;
    logic [1:0]    last_k;

    // A count of zero runs the body once, same as a count of one.
    function automatic logic [AW-1:0] last_iter(input logic [AW-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    assign last_k = (mode_q == 2'd0) ? 2'd0 :
                    (mode_q == 2'd1) ? 2'd1 : 2'd2;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mode_d  = mode_q;
        iter_d  = iter_q;
        jump_d  = jump_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        jumped  = 1'b0;
        if (clr_i) begin
            state_d = StIdle;
            pc_d    = '0;
            iter_d  = '0;
        end else if (state_q == StIdle) begin
            if (start_i) begin
                state_d = StRun;
                pc_d    = '0;
                iter_d  = '0;
                mode_d  = loop_mode_i;
                jump_d  = {jump_addr3_i, jump_addr2_i, jump_addr1_i};
                end_d   = {end_addr3_i, end_addr2_i, end_addr1_i};
                cnt_d   = {count3_i, count2_i, count1_i};
            end
        end else if (!stall_i) begin
            // Innermost first; an exhausted loop passes control outward.
            for (int k = 0; k < 3; k++) begin
                if (!jumped && k <= int'(last_k) && pc_q == end_q[k]) begin
                    if (iter_q[k] != last_iter(cnt_q[k])) begin
                        iter_d[k] = iter_q[k] + 1'b1;
                        pc_d      = jump_q[k];
                        jumped    = 1'b1;
                    end else begin
                        iter_d[k] = '0;
                    end
                end
            end
            if (!jumped) begin
                if (pc_q == end_q[last_k]) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    pc_d    = '0;
                    iter_d  = '0;
                end else begin
                    pc_d = (pc_q == LastAddr) ? '0 : pc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= '0;
            mode_q  <= '0;
            iter_q  <= '0;
            jump_q  <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mode_q  <= mode_d;
            iter_q  <= iter_d;
            jump_q  <= jump_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign pc_o         = pc_q;
    assign inst_valid_o = (state_q == StRun);
    assign busy_o       = (state_q == StRun);
    assign done_o       = done_q;

`ifdef INST_LOOP_CTRL_PERF_CNT_EN
    logic [PerfCntWidth-1:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (clr_i) begin
            perf_q <= '0;
        end else if (state_q == StIdle && start_i) begin
            perf_q <= '0;
        end else if (state_q == StRun && perf_q != '1) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_inst_loop_ctrl.sv
// Directed bench for inst_loop_ctrl: loop sequences, stall, clear,
// mid-run start/config changes, optional perf counter.
module tb_inst_loop_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i, clr_i, stall_i;
    logic [1:0] mode;
    logic [4:0] j1, j2, j3, e1, e2, e3, c1, c2, c3;
    logic [4:0] pc_o;
    logic       inst_valid_o, busy_o, done_o;
    logic [31:0] perf_cycles_o;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit stl_q[$];

    inst_loop_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .clr_i        (clr_i),
        .stall_i      (stall_i),
        .loop_mode_i  (mode),
        .jump_addr1_i (j1),
        .jump_addr2_i (j2),
        .jump_addr3_i (j3),
        .end_addr1_i  (e1),
        .end_addr2_i  (e2),
        .end_addr3_i  (e3),
        .count1_i     (c1),
        .count2_i     (c2),
        .count3_i     (c3),
        .pc_o         (pc_o),
        .inst_valid_o (inst_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .perf_cycles_o(perf_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] m,
                       input int a1, input int b1, input int n1,
                       input int a2, input int b2, input int n2,
                       input int a3, input int b3, input int n3);
        mode = m;
        j1 = 5'(a1); e1 = 5'(b1); c1 = 5'(n1);
        j2 = 5'(a2); e2 = 5'(b2); c2 = 5'(n2);
        j3 = 5'(a3); e3 = 5'(b3); c3 = 5'(n3);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Start, then walk exp_q cycle by cycle; stl_q gives stall per cycle.
    // At index poke, start_i is re-asserted and loop-1 config is altered.
    task automatic run(input string tag, input int poke);
        int n;
        int perf_exp;
        n = exp_q.size();
        pulse_start();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_pc"}, int'(pc_o), exp_q[i]);
            chk({tag, "_valid"}, int'(inst_valid_o), 1);
            chk({tag, "_busy"}, int'(busy_o), 1);
            chk({tag, "_nodone"}, int'(done_o), 0);
            stall_i = (i < stl_q.size()) ? stl_q[i] : 1'b0;
            if (i == poke) begin
                start_i = 1'b1;
                c1 = 5'd1; j1 = 5'd0; e1 = 5'd1; mode = 2'd2;
            end else begin
                start_i = 1'b0;
            end
            step();
        end
        stall_i = 1'b0;
        start_i = 1'b0;
`ifdef INST_LOOP_CTRL_PERF_CNT_EN
        perf_exp = n;
`else
        perf_exp = 0;
`endif
        chk({tag, "_done"}, int'(done_o), 1);
        chk({tag, "_busy_end"}, int'(busy_o), 0);
        chk({tag, "_valid_end"}, int'(inst_valid_o), 0);
        chk({tag, "_pc_end"}, int'(pc_o), 0);
        chk({tag, "_perf"}, int'(perf_cycles_o), perf_exp);
        step();
        chk({tag, "_done_pulse"}, int'(done_o), 0);
        chk({tag, "_idle_pc"}, int'(pc_o), 0);
    endtask

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0; clr_i = 1'b0; stall_i = 1'b0;
        cfg(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_pc", int'(pc_o), 0);
        chk("rst_valid", int'(inst_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_perf", int'(perf_cycles_o), 0);
        step(); step();
        rst_ni = 1'b1;
        step();
        chk("idle_busy", int'(busy_o), 0);

        // Single loop.
        cfg(2'd0, 2, 4, 3, 0, 0, 0, 0, 0, 0);
        exp_q = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4};
        stl_q = {};
        run("single", -1);

        // Two nested loops.
        cfg(2'd1, 1, 2, 2, 0, 3, 2, 0, 0, 0);
        exp_q = '{0, 1, 2, 1, 2, 3, 0, 1, 2, 1, 2, 3};
        run("nested", -1);

        // Shared end address.
        cfg(2'd1, 1, 2, 2, 0, 2, 2, 0, 0, 0);
        exp_q = '{0, 1, 2, 1, 2, 0, 1, 2, 1, 2};
        run("shared", -1);

        // Count zero behaves as one.
        cfg(2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        exp_q = '{0, 1};
        run("cnt0", -1);

        // Three loops, middle one count 0 with end inside outer.
        cfg(2'd2, 1, 1, 2, 0, 2, 0, 0, 3, 2);
        exp_q = '{0, 1, 1, 2, 3, 0, 1, 1, 2, 3};
        run("three", -1);

        // Stall three cycles at pc=3.
        cfg(2'd0, 2, 4, 3, 0, 0, 0, 0, 0, 0);
        exp_q = '{0, 1, 2, 3, 3, 3, 3, 4, 2, 3, 4, 2, 3, 4};
        stl_q = '{0, 0, 0, 1, 1, 1, 0};
        run("stall", -1);
        stl_q = {};

        // Clear at pc=3 together with start.
        cfg(2'd0, 2, 4, 3, 0, 0, 0, 0, 0, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("clr_pre_pc", int'(pc_o), i);
            if (i == 3) begin
                clr_i = 1'b1;
                start_i = 1'b1;
            end
            step();
        end
        clr_i = 1'b0;
        start_i = 1'b0;
        chk("clr_pc", int'(pc_o), 0);
        chk("clr_busy", int'(busy_o), 0);
        chk("clr_valid", int'(inst_valid_o), 0);
        chk("clr_done", int'(done_o), 0);
        chk("clr_perf", int'(perf_cycles_o), 0);
        step();
        chk("clr_done2", int'(done_o), 0);
        chk("clr_busy2", int'(busy_o), 0);
        exp_q = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4};
        run("replay", -1);

        // Start and config change while running.
        cfg(2'd0, 2, 4, 3, 0, 0, 0, 0, 0, 0);
        run("busy_cfg", 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
